// File: rtl/alu_arbiter.sv
// Round-robin front end for the shared 8-bit ALU.
// Two requesters share the ALU. Each op is held for a set latency, then answered over a tagged valid/ready response.
module alu_arbiter #(
  parameter int BASE_LAT   = 1,
  parameter int MULDIV_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic        rsp_err,
  output logic        busy,
  output logic [15:0] op_count
);

  localparam int MAX_LAT = (BASE_LAT > MULDIV_LAT) ? BASE_LAT : MULDIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_LAST = 4'd12;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_q, state_d;
  logic [3:0]         alu_op_q, alu_op_d;
  logic [7:0]         alu_a_q, alu_a_d;
  logic [7:0]         alu_b_q, alu_b_d;
  logic               rsp_id_q, rsp_id_d;
  logic [15:0]        rsp_result_q, rsp_result_d;
  logic               rsp_err_q, rsp_err_d;
  logic [15:0]        op_count_q, op_count_d;
  logic               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               grant_valid;
  logic               grant_idx;
  logic [3:0]         sel_op;
  logic [7:0]         sel_a;
  logic [7:0]         sel_b;
  logic               sel_err;
  logic               sel_muldiv;

  // Grant only exists in IDLE; on contention the requester not served last wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_idx   = ~last_grant_q;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_idx   = 1'b1;
      end
    end
  end

  assign sel_op     = grant_idx ? req1_op : req0_op;
  assign sel_a      = grant_idx ? req1_a  : req0_a;
  assign sel_b      = grant_idx ? req1_b  : req0_b;
  assign sel_err    = (sel_op > OP_LAST) || ((sel_op == OP_DIV) && (sel_b == 8'd0));
  assign sel_muldiv = (sel_op == OP_MUL) || (sel_op == OP_DIV);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      alu_op_q     <= OP_NOP;
      alu_a_q      <= 8'd0;
      alu_b_q      <= 8'd0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 16'd0;
      rsp_err_q    <= 1'b0;
      op_count_q   <= 16'd0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      op_count_q   <= op_count_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (grant_valid) state_d = sel_err ? RESP : EXEC;
      EXEC: if (cnt_q == '0) state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Error ops park the ALU on NOP with zero operands and answer without executing.
  always_comb begin
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    op_count_d   = op_count_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          rsp_id_d     = grant_idx;
          last_grant_d = grant_idx;
          cnt_d        = sel_muldiv ? CNT_W'(MULDIV_LAT - 1) : CNT_W'(BASE_LAT - 1);
          if (sel_err) begin
            alu_op_d     = OP_NOP;
            alu_a_d      = 8'd0;
            alu_b_d      = 8'd0;
            rsp_err_d    = 1'b1;
            rsp_result_d = 16'hFFFF;
          end else begin
            alu_op_d = sel_op;
            alu_a_d  = sel_a;
            alu_b_d  = sel_b;
          end
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rsp_result_d = alu_result;
          rsp_err_d    = 1'b0;
        end
      end
      RESP: if (rsp_ready) op_count_d = op_count_q + 16'd1;
      default: ;
    endcase
  end

  always_comb begin
    req0_ready = grant_valid && !grant_idx;
    req1_ready = grant_valid && grant_idx;
    rsp_valid  = (state_q == RESP);
    busy       = (state_q != IDLE);
    alu_op     = alu_op_q;
    alu_a      = alu_a_q;
    alu_b      = alu_b_q;
    rsp_id     = rsp_id_q;
    rsp_result = rsp_result_q;
    rsp_err    = rsp_err_q;
    op_count   = op_count_q;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Sequences and shares the single combinational 8-bit `alu` (8-bit operands, 16-bit result) between two requesters.
- Arbitrates round-robin and registers the operands and opcode into the ALU.
- Holds each op for a programmable number of cycles, with longer latency for MUL/DIV, then returns a registered, tagged result over a valid/ready response channel.
- Sits between the issuing controllers and the ALU instance. It is the only driver of the ALU's a/b/opcode inputs.

Parameters:
- BASE_LAT, 1, EXEC cycles for all ops except MUL/DIV (min 1)
- MULDIV_LAT, 4, EXEC cycles for OP_MUL and OP_DIV (min 1)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has an op
- req0_ready  output  1  requester 0 op accepted this cycle
- req0_op  input  4  opcode, shared ALU opcode encoding
- req0_a  input  8  operand a
- req0_b  input  8  operand b
- req1_valid / req1_ready / req1_op / req1_a / req1_b  same as requester 0, for requester 1
- alu_op  output  4  to ALU opcode
- alu_a  output  8  to ALU a
- alu_b  output  8  to ALU b
- alu_result  input  16  from ALU result
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  1  requester that issued the op
- rsp_result  output  16  registered result
- rsp_err  output  1  illegal opcode or divide-by-zero
- busy  output  1  state != IDLE
- op_count  output  16  completed responses, wraps at 0xFFFF to 0

Behaviour:
- Reset (async, immediate):
  - state=IDLE; alu_op=0 (OP_NOP), alu_a=0, alu_b=0.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, op_count=0.
  - last_grant=1, so requester 0 wins first.
  - Reset mid-operation discards the in-flight op with no response.
- Opcodes: OP_NOP=0 … OP_SMR=12 per the shared ALU header; OP_MUL=3, OP_DIV=4. Codes 13–15 are illegal.
- States: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational: only the granted requester sees ready=1, and only when it is valid.
  - Both valid: grant goes to !last_grant.
  - One valid: that one is granted.
  - Neither valid: no grant.
  - Transfer occurs on valid&ready at the clock edge. At that edge: latch op/a/b into alu_op/alu_a/alu_b, set rsp_id and last_grant to the granted index, and load cnt = lat-1, where lat = MULDIV_LAT for MUL/DIV, else BASE_LAT.
  - Then go to EXEC, except in the error case below.
- Error case (decided at the transfer edge):
  - Condition: illegal opcode, or OP_DIV with b==0.
  - Skip EXEC and go directly to RESP with rsp_err=1 and rsp_result=16'hFFFF.
  - alu_op is loaded with OP_NOP, alu_a/alu_b with 0.
- EXEC:
  - alu_* are held stable.
  - cnt!=0: decrement.
  - cnt==0: latch alu_result into rsp_result, set rsp_err=0, go to RESP.
- RESP:
  - rsp_valid=1; rsp_id/rsp_result/rsp_err are held stable until accepted.
  - On rsp_ready=1: op_count+=1 (wrapping) and return to IDLE.
  - No new request is accepted in RESP or EXEC (ready=0). The earliest new accept is the cycle after the response handshake.
- Latency, normal op: accept edge → rsp_valid rises lat cycles later. BASE_LAT=1 means rsp_valid is high in the 2nd cycle after accept.
- Requesters must hold valid/op/a/b stable until ready. Dropping valid without ready is legal and grants nothing.
- rsp_ready asserted while rsp_valid=0 is ignored.
- op_count counts error responses too.
- busy = (state != IDLE), registered from state.

Test Plan:
- Reset, req0 ADD a=0x55 b=0x03, rsp_ready=1 → req0_ready=1 in cycle 0; rsp_valid in cycle 2; rsp_id=0, rsp_result=0x0058, rsp_err=0, op_count=1.
- req0 MUL a=0x55 b=0x03, MULDIV_LAT=4 → alu_op=3 stable for 4 EXEC cycles; rsp_result=0x00FF five cycles after accept.
- req0 and req1 both continuously valid with ADD → grants alternate 0,1,0,1 (first grant to 0); rsp_id sequence 0,1,0,1.
- DIV a=0x55 b=0x00 → no EXEC; rsp_valid the cycle after accept with rsp_err=1, rsp_result=0xFFFF. Opcode 4'hF → same error response.
- Hold rsp_ready=0 for 5 cycles in RESP while req1 valid → rsp outputs are stable, req1_ready=0 throughout. After the handshake, req1 is accepted on the next cycle.
- Assert rst during EXEC of a MUL → all outputs return to reset values immediately, no response for the discarded op. After release, a new ADD completes normally with op_count=1.
